mem2_load_collect: RTL and testbench
====================================

Name: mem2_load_collect

Overview:
- Consumer end of the MEM→MEM2 pipeline register, located in the MEM2 stage.
- Takes the load request issued in MEM and sitting in MEM2, waits for the data-cache read response, and aligns and sign/zero-extends the returned word.
- Presents the writeback result to the WB register and raises a stall while the response is outstanding.
- Buffers a response that arrives while WB is not accepting, and discards responses belonging to flushed loads.

Parameters:
- DATA_W, 32, data and address width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- MEM2_Flush  in  1  MEM2 instruction killed this cycle
- WB_Wr  in  1  WB register captures the MEM2 result at this edge
- MEM2_LoadType  in  LoadType  ReadMem, Sign, Size[1:0] (00 byte, 01 half, 10 word)
- MEM2_ALUOut  in  32  effective address / ALU result
- MEM2_WbSel  in  2  writeback select
- MEM2_ExcType  in  5  nonzero means excepted; no data is expected
- dcache_data_ok  in  1  read response valid, one cycle per request, in request order
- dcache_rdata  in  32  response word
- MEM2_Result  out  32  value forwarded to WB
- MEM2_DataStall  out  1  hazard unit must hold MEM2 and earlier stages
- MEM2_LoadBusy  out  1  a response is outstanding, including a flushed one

Behaviour:
- need = MEM2_LoadType.ReadMem && MEM2_ExcType==0 && !MEM2_Flush.
- States:
  - PASS: no outstanding load for the current instruction.
  - WAIT: current load issued, data not yet returned.
  - HOLD: data captured in hold_q, WB not yet taken.
  - DRAIN: one stale response still owed for a flushed load.
- PASS:
  - !need: result = MEM2_ALUOut; stall=0; stay.
  - need && data_ok: result = align(rdata); stall=0. WB_Wr → PASS; else → HOLD and hold_q <= align(rdata).
  - need && !data_ok: stall=1; → WAIT.
- WAIT:
  - data_ok: result = align(rdata); stall=0. WB_Wr → PASS; else → HOLD and capture.
  - no data_ok: stall=1.
  - MEM2_Flush without data_ok: → DRAIN.
  - MEM2_Flush with data_ok: response discarded; → PASS.
- HOLD:
  - result = hold_q; stall=0.
  - WB_Wr or MEM2_Flush → PASS.
  - data_ok in HOLD is a protocol error; ignore it (assertion in bench).
- DRAIN:
  - First data_ok is discarded, never forwarded.
  - If need is true in the same cycle, stall=1 and go to WAIT; otherwise go to PASS.
  - Before that data_ok arrives: stall = need; result = MEM2_ALUOut.
  - MEM2_Flush in DRAIN keeps DRAIN (only one stale response is owed).
- MEM2_LoadBusy = 1 in WAIT and DRAIN.
- align():
  - off = ALUOut[1:0].
  - Byte: rdata[8*off+7 : 8*off].
  - Half: off[1] ? rdata[31:16] : rdata[15:0]; off[0] is ignored because misalignment was already trapped in MEM.
  - Word: rdata.
  - Sign=1 sign-extends to 32; Sign=0 zero-extends.
- Output mux: result is the aligned load data only when WbSel == WBSel_MemOut; otherwise result = MEM2_ALUOut in all states.
- Reset (rst==0 at an edge):
  - state=PASS, hold_q=0.
  - Outputs combinationally become MEM2_Result=MEM2_ALUOut, MEM2_DataStall=0, MEM2_LoadBusy=0.
  - Reset mid-WAIT abandons the response; the cache is reset in the same cycle.
- Latency: zero cycles from data_ok to MEM2_Result (combinational path); one register stage only for the HOLD path.

Decomposition:
- Shared package (CPU_Defines): LoadType struct, Size encodings, WBSel_MemOut, and the state enum (PASS/WAIT/HOLD/DRAIN).
- One natural sub-module: load_align (pure combinational byte/half select and extension), reused by the forwarding path.

Test Plan:
- LB at addr 0x...3, rdata 0x80AA5511, data_ok the same cycle, WB_Wr=1 → result 0xFFFFFF80, stall never 1.
- LHU at addr 0x...2, data_ok 3 cycles late, rdata 0x8001_1234 → stall=1 for 3 cycles, then result 0x00008001, state PASS.
- LW with data_ok while WB_Wr=0 for 2 cycles, rdata 0xDEADBEEF → HOLD, result 0xDEADBEEF held for 2 cycles with stall=0, hold_q unchanged when rdata changes.
- LW in WAIT, MEM2_Flush, next instruction is LW to 0x100; stale data_ok 0x11111111, then data_ok 0x22222222 → first discarded, result 0x22222222, stall=1 until the second data_ok.
- Non-load, WbSel=ALU, ALUOut 0x1234 with a spurious data_ok → result 0x1234, stall=0.
- rst=0 during WAIT → next cycle state PASS, stall=0, LoadBusy=0, hold_q=0.

Source files
------------

// File: rtl/mem2_load_collect_pkg.sv
// Shared types for the MEM2 load-collect stage: load descriptor, size codes,
// writeback select encodings and the collector state enum.
package mem2_load_collect_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10
  } load_size_e;

  typedef struct packed {
    logic       ReadMem;
    logic       Sign;
    logic [1:0] Size;
  } load_type_t;

  localparam logic [1:0] WBSel_ALUOut = 2'b00;
  localparam logic [1:0] WBSel_MemOut = 2'b01;

  // PASS: nothing owed, WAIT: response pending, HOLD: response parked for WB,
  // DRAIN: one response still owed to a flushed load.
  typedef enum logic [1:0] {
    PASS  = 2'b00,
    WAIT  = 2'b01,
    HOLD  = 2'b10,
    DRAIN = 2'b11
  } collect_state_e;

endpackage

// File: rtl/mem2_load_collect_align.sv
// Byte/half/word lane select and sign/zero extension of a returned data word.
// Purely combinational so the forwarding path can reuse it.
module mem2_load_collect_align
  import mem2_load_collect_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              sign,
  input  logic [1:0]        size,
  input  logic [1:0]        off,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[8*off +: 8];
    // off[0] is ignored for halves: a misaligned half already trapped in MEM.
    half_sel = off[1] ? rdata[31:16] : rdata[15:0];
    data     = rdata;
    case (size)
      SIZE_BYTE: data = {{(DATA_W-8){sign & byte_sel[7]}}, byte_sel};
      SIZE_HALF: data = {{(DATA_W-16){sign & half_sel[15]}}, half_sel};
      default:   data = rdata;
    endcase
  end

endmodule

// File: rtl/mem2_load_collect.sv
// MEM2-stage load collector: waits for the data-cache response, aligns it,
// stalls while it is outstanding, parks it for WB and drains flushed responses.
module mem2_load_collect
  import mem2_load_collect_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MEM2_Flush,
  input  logic              WB_Wr,
  input  load_type_t        MEM2_LoadType,
  input  logic [DATA_W-1:0] MEM2_ALUOut,
  input  logic [1:0]        MEM2_WbSel,
  input  logic [4:0]        MEM2_ExcType,
  input  logic              dcache_data_ok,
  input  logic [DATA_W-1:0] dcache_rdata,
  output logic [DATA_W-1:0] MEM2_Result,
  output logic              MEM2_DataStall,
  output logic              MEM2_LoadBusy,
  output collect_state_e    debug_state,
  output logic [DATA_W-1:0] debug_hold
);

  // Handshake: dcache_data_ok is a one-cycle valid with no ready; exactly one
  // pulse per issued request, in request order. WB_Wr is the WB register's
  // accept; a result not accepted at the edge it is shown must be parked.
  collect_state_e    state;
  logic [DATA_W-1:0] hold_q;
  logic [DATA_W-1:0] aligned;
  logic [DATA_W-1:0] mem_value;
  logic              need;
  logic              mem_valid;
  logic              stall_c;

  mem2_load_collect_align #(.DATA_W(DATA_W)) u_align (
    .sign  (MEM2_LoadType.Sign),
    .size  (MEM2_LoadType.Size),
    .off   (MEM2_ALUOut[1:0]),
    .rdata (dcache_rdata),
    .data  (aligned)
  );

  assign need = MEM2_LoadType.ReadMem && (MEM2_ExcType == 5'd0) && !MEM2_Flush;

  always_comb begin
    mem_valid = 1'b0;
    mem_value = aligned;
    stall_c   = 1'b0;
    case (state)
      PASS: begin
        mem_valid = need && dcache_data_ok;
        stall_c   = need && !dcache_data_ok;
      end
      WAIT: begin
        mem_valid = dcache_data_ok && !MEM2_Flush;
        stall_c   = !dcache_data_ok;
      end
      HOLD: begin
        mem_valid = 1'b1;
        mem_value = hold_q;
      end
      DRAIN: stall_c = need;
      default: ;
    endcase
  end

  // Reset forces the pass-through view immediately, not one edge later.
  assign MEM2_Result    = (rst && mem_valid && (MEM2_WbSel == WBSel_MemOut))
                          ? mem_value : MEM2_ALUOut;
  assign MEM2_DataStall = rst && stall_c;
  assign MEM2_LoadBusy  = rst && ((state == WAIT) || (state == DRAIN));
  assign debug_state    = state;
  assign debug_hold     = hold_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= PASS;
      hold_q <= '0;
    end else begin
      case (state)
        PASS: begin
          if (need) begin
            if (!dcache_data_ok) begin
              state <= WAIT;
            end else if (!WB_Wr) begin
              state  <= HOLD;
              hold_q <= aligned;
            end
          end
        end
        WAIT: begin
          if (dcache_data_ok) begin
            if (MEM2_Flush || WB_Wr) begin
              state <= PASS;
            end else begin
              state  <= HOLD;
              hold_q <= aligned;
            end
          end else if (MEM2_Flush) begin
            state <= DRAIN;
          end
        end
        HOLD: begin
          // A response here would break the one-per-request contract; ignored.
          if (WB_Wr || MEM2_Flush) state <= PASS;
        end
        DRAIN: begin
          if (dcache_data_ok) state <= need ? WAIT : PASS;
        end
        default: state <= PASS;
      endcase
    end
  end

endmodule

// File: tb/tb_mem2_load_collect.sv
// Directed and randomized checks of the MEM2 load collector against a
// transaction-level model of load latency, writeback delay and flushes.
module tb_mem2_load_collect;
  import mem2_load_collect_pkg::*;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           flush;
  logic           wb_wr;
  load_type_t     ld;
  logic [W-1:0]   alu;
  logic [1:0]     wbsel;
  logic [4:0]     exc;
  logic           ok;
  logic [W-1:0]   rdata;
  logic [W-1:0]   result;
  logic           stall;
  logic           busy;
  collect_state_e dstate;
  logic [W-1:0]   dhold;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  logic [W-1:0] exp_q[$];

  mem2_load_collect #(.DATA_W(W)) dut (
    .clk            (clk),
    .rst            (rst),
    .MEM2_Flush     (flush),
    .WB_Wr          (wb_wr),
    .MEM2_LoadType  (ld),
    .MEM2_ALUOut    (alu),
    .MEM2_WbSel     (wbsel),
    .MEM2_ExcType   (exc),
    .dcache_data_ok (ok),
    .dcache_rdata   (rdata),
    .MEM2_Result    (result),
    .MEM2_DataStall (stall),
    .MEM2_LoadBusy  (busy),
    .debug_state    (dstate),
    .debug_hold     (dhold)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // A parked result must never see a new response.
  always @(negedge clk) begin
    if (rst === 1'b1 && dstate == HOLD) begin
      checks++;
      assert (ok !== 1'b1) passes++;
      else begin
        fails++;
        $error("FAIL protocol_hold observed=%0d expected=0", ok);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic set_idle();
    ld    = '0;
    flush = 1'b0;
    wb_wr = 1'b1;
    alu   = $urandom;
    wbsel = WBSel_ALUOut;
    exc   = 5'd0;
    ok    = 1'b0;
    rdata = $urandom;
  endtask

  task automatic set_load(input logic [1:0] size, input logic sign, input logic [W-1:0] addr);
    ld.ReadMem = 1'b1;
    ld.Sign    = sign;
    ld.Size    = size;
    alu        = addr;
    wbsel      = WBSel_MemOut;
    exc        = 5'd0;
    flush      = 1'b0;
  endtask

  function automatic logic [W-1:0] ref_align(input logic [1:0] size, input logic sign,
                                             input logic [W-1:0] addr, input logic [W-1:0] d);
    int unsigned v;
    int unsigned off;
    off = addr % 4;
    case (size)
      2'd0: begin
        v = (d >> (8 * off)) % 256;
        if (sign && v >= 128) v = v + 32'hFFFF_FF00;
      end
      2'd1: begin
        v = (off >= 2) ? d / 65536 : d % 65536;
        if (sign && v >= 32768) v = v + 32'hFFFF_0000;
      end
      default: v = d;
    endcase
    return v;
  endfunction

  initial begin
    logic [1:0]   size;
    logic         sign;
    logic [W-1:0] addr;
    logic [W-1:0] data;
    logic [W-1:0] e;
    int           kind;
    int           lat;
    int           dly;
    int           gap;

    set_idle();
    rst = 1'b0;
    step();
    sample();
    chk("reset_stall", {31'b0, stall}, 32'd0);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_result", result, alu);
    chk("reset_state", {30'b0, dstate}, {30'b0, PASS});
    chk("reset_hold", dhold, 32'd0);
    step();
    rst = 1'b1;

    // LB hit in the issue cycle
    set_idle();
    set_load(2'd0, 1'b1, 32'h0000_1003);
    ok = 1'b1; rdata = 32'h80AA_5511; wb_wr = 1'b1;
    sample();
    chk("lb_result", result, 32'hFFFF_FF80);
    chk("lb_stall", {31'b0, stall}, 32'd0);
    step();
    set_idle();
    sample();
    chk("lb_state", {30'b0, dstate}, {30'b0, PASS});
    step();

    // LHU with three cycles of latency
    set_load(2'd1, 1'b0, 32'h0000_2002);
    ok = 1'b0; wb_wr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("lhu_wait_stall", {31'b0, stall}, 32'd1);
      step();
    end
    ok = 1'b1; rdata = 32'h8001_1234; wb_wr = 1'b1;
    sample();
    chk("lhu_result", result, 32'h0000_8001);
    chk("lhu_stall", {31'b0, stall}, 32'd0);
    step();
    set_idle();
    sample();
    chk("lhu_state", {30'b0, dstate}, {30'b0, PASS});
    step();

    // LW response while WB is not accepting: parked for two cycles
    set_load(2'd2, 1'b0, 32'h0000_3000);
    ok = 1'b1; rdata = 32'hDEAD_BEEF; wb_wr = 1'b0;
    sample();
    chk("lw_hold_first", result, 32'hDEAD_BEEF);
    step();
    ok = 1'b0; rdata = 32'h1234_5678; wb_wr = 1'b0;
    sample();
    chk("lw_hold_result1", result, 32'hDEAD_BEEF);
    chk("lw_hold_stall1", {31'b0, stall}, 32'd0);
    chk("lw_hold_state", {30'b0, dstate}, {30'b0, HOLD});
    chk("lw_hold_q", dhold, 32'hDEAD_BEEF);
    step();
    rdata = 32'hCAFE_F00D; wb_wr = 1'b1;
    sample();
    chk("lw_hold_result2", result, 32'hDEAD_BEEF);
    chk("lw_hold_stall2", {31'b0, stall}, 32'd0);
    chk("lw_hold_q2", dhold, 32'hDEAD_BEEF);
    step();
    set_idle();
    sample();
    chk("lw_hold_exit", {30'b0, dstate}, {30'b0, PASS});
    step();

    // Flushed LW followed by LW to 0x100; stale response dropped
    set_load(2'd2, 1'b0, 32'h0000_4000);
    ok = 1'b0; wb_wr = 1'b0;
    sample();
    chk("fl_issue_stall", {31'b0, stall}, 32'd1);
    step();
    flush = 1'b1;
    sample();
    chk("fl_flush_busy", {31'b0, busy}, 32'd1);
    step();
    set_load(2'd2, 1'b0, 32'h0000_0100);
    wb_wr = 1'b0;
    sample();
    chk("fl_drain_state", {30'b0, dstate}, {30'b0, DRAIN});
    chk("fl_drain_stall", {31'b0, stall}, 32'd1);
    chk("fl_drain_result", result, 32'h0000_0100);
    chk("fl_drain_busy", {31'b0, busy}, 32'd1);
    step();
    ok = 1'b1; rdata = 32'h1111_1111;
    sample();
    chk("fl_stale_result", result, 32'h0000_0100);
    chk("fl_stale_stall", {31'b0, stall}, 32'd1);
    step();
    rdata = 32'h2222_2222; wb_wr = 1'b1;
    sample();
    chk("fl_new_result", result, 32'h2222_2222);
    chk("fl_new_stall", {31'b0, stall}, 32'd0);
    chk("fl_new_busy", {31'b0, busy}, 32'd1);
    step();
    set_idle();
    sample();
    chk("fl_end_state", {30'b0, dstate}, {30'b0, PASS});
    step();

    // Non-load with a spurious response
    set_idle();
    alu = 32'h0000_1234; ok = 1'b1;
    sample();
    chk("alu_result", result, 32'h0000_1234);
    chk("alu_stall", {31'b0, stall}, 32'd0);
    step();
    ok = 1'b0;
    sample();
    chk("alu_state", {30'b0, dstate}, {30'b0, PASS});
    step();

    // Reset while a response is outstanding
    set_load(2'd2, 1'b0, 32'h0000_5000);
    ok = 1'b0; wb_wr = 1'b0;
    sample();
    step();
    rst = 1'b0;
    sample();
    chk("rstw_stall", {31'b0, stall}, 32'd0);
    chk("rstw_busy", {31'b0, busy}, 32'd0);
    chk("rstw_result", result, 32'h0000_5000);
    step();
    rst = 1'b1;
    set_idle();
    sample();
    chk("rstw_state", {30'b0, dstate}, {30'b0, PASS});
    chk("rstw_stall2", {31'b0, stall}, 32'd0);
    chk("rstw_busy2", {31'b0, busy}, 32'd0);
    chk("rstw_hold", dhold, 32'd0);
    step();

    // Randomized transactions
    for (int n = 0; n < 80; n++) begin
      set_idle();
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        wbsel = 2'($urandom_range(0, 3));
        ok = 1'($urandom_range(0, 1));
        sample();
        chk("rnd_alu_result", result, alu);
        chk("rnd_alu_stall", {31'b0, stall}, 32'd0);
        step();
      end else if (kind == 1) begin
        set_load(2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), $urandom);
        exc = 5'($urandom_range(1, 31));
        sample();
        chk("rnd_exc_result", result, alu);
        chk("rnd_exc_stall", {31'b0, stall}, 32'd0);
        step();
      end else if (kind == 2) begin
        set_load(2'd2, 1'b0, {$urandom} & 32'hFFFF_FFFC);
        wb_wr = 1'b0;
        sample();
        chk("rnd_fl_stall", {31'b0, stall}, 32'd1);
        step();
        flush = 1'b1;
        sample();
        chk("rnd_fl_busy", {31'b0, busy}, 32'd1);
        step();
        set_idle();
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) begin
          sample();
          chk("rnd_drain_stall", {31'b0, stall}, 32'd0);
          chk("rnd_drain_busy", {31'b0, busy}, 32'd1);
          step();
        end
        ok = 1'b1; wbsel = WBSel_MemOut;
        sample();
        chk("rnd_stale_result", result, alu);
        chk("rnd_stale_busy", {31'b0, busy}, 32'd1);
        step();
        ok = 1'b0;
        sample();
        chk("rnd_drain_done", {31'b0, busy}, 32'd0);
        step();
      end else begin
        size = 2'($urandom_range(0, 2));
        sign = 1'($urandom_range(0, 1));
        addr = $urandom;
        if (size == 2'd1) addr[0] = 1'b0;
        if (size == 2'd2) addr[1:0] = 2'b00;
        data = $urandom;
        lat  = $urandom_range(0, 3);
        dly  = $urandom_range(0, 2);
        set_load(size, sign, addr);
        if ($urandom_range(0, 3) == 0) wbsel = WBSel_ALUOut;
        exp_q.push_back((wbsel == WBSel_MemOut) ? ref_align(size, sign, addr, data) : addr);
        for (int i = 0; i < lat; i++) begin
          ok = 1'b0; wb_wr = 1'b0; rdata = $urandom;
          sample();
          chk("rnd_wait_stall", {31'b0, stall}, 32'd1);
          chk("rnd_wait_busy", {31'b0, busy}, (i > 0) ? 32'd1 : 32'd0);
          chk("rnd_wait_result", result, addr);
          step();
        end
        ok = 1'b1; rdata = data; wb_wr = (dly == 0);
        sample();
        e = exp_q.pop_front();
        chk("rnd_data_result", result, e);
        chk("rnd_data_stall", {31'b0, stall}, 32'd0);
        chk("rnd_data_busy", {31'b0, busy}, (lat > 0) ? 32'd1 : 32'd0);
        step();
        for (int j = 0; j < dly; j++) begin
          ok = 1'b0; rdata = $urandom; wb_wr = (j == dly - 1);
          sample();
          chk("rnd_hold_result", result, e);
          chk("rnd_hold_stall", {31'b0, stall}, 32'd0);
          step();
        end
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
